priority_arbiter_4_req: RTL and testbench
=========================================

PRIORITY_ARBITER_4_REQ -- requirements
Module: priority_arbiter_4_req

Interface
REQ-001 The block SHALL provide parameter MAX_WAIT, default 8, meaning the number of wait cycles after which a requester becomes starved (legal range 1..15).
REQ-002 The block SHALL provide parameter HOLD_MAX, default 16, meaning the maximum consecutive cycles one owner may hold the grant (legal range 1..31).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  4  request lines; bit 3 has the highest static priority, bit 0 the lowest.
- gnt  output 4  one-hot grant; all zeros when there is no owner.
- gnt_id  output 2  binary index of the current owner; 0 when gnt is zero.
- gnt_valid  output 1  high exactly when gnt is non-zero.
- timeout  output 1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-004 The block SHALL implement the states IDLE and GRANT, registered, with IDLE as the reset state.
REQ-005 In IDLE with req == 0, the block SHALL remain in IDLE with gnt = 0.
REQ-006 In IDLE with req != 0 at a clock edge, the block SHALL enter GRANT at that edge and assert gnt for the winner, giving a latency of 1 cycle from sampled req to gnt.
REQ-007 Winner selection SHALL follow these rules:
- If any requesting bit is starved (wait_cnt[i] >= MAX_WAIT), the winner is the highest-index starved bit.
- Otherwise the winner is the highest-index set bit of req.
REQ-008 In GRANT, gnt, gnt_id and the owner SHALL hold constant while req[owner] is sampled 1 and the hold counter is below HOLD_MAX; changes on other req bits SHALL NOT preempt the owner.
REQ-009 In GRANT, when req[owner] is sampled 0, the block SHALL return to IDLE and drive gnt = 0 from that edge, so at least one idle cycle separates consecutive grants.
REQ-010 A per-grant hold counter SHALL work as follows:
- It is loaded to 1 on entry to GRANT and increments each GRANT cycle.
- When it equals HOLD_MAX and req[owner] is still 1, the block returns to IDLE, drives gnt = 0, and pulses timeout for exactly 1 cycle.
REQ-011 After a timeout, the revoked requester SHALL be excluded from the next arbitration only, even if it is starved; it is eligible again afterwards.
REQ-012 Each requester i SHALL have a 4-bit saturating wait_cnt[i] that behaves as follows:
- It increments on each edge where req[i] = 1 and gnt[i] = 0.
- It clears when req[i] = 0 or when i is granted.
- It saturates at 15.
REQ-013 If req[owner] drops and other requests are present in the same cycle, the drop SHALL take effect first (return to IDLE); the others SHALL be arbitrated at the following edge.
REQ-014 The outputs gnt, gnt_id and gnt_valid SHALL be driven from registers only, with no combinational path from req.
REQ-015 The invariant popcount(gnt) <= 1 SHALL hold in every cycle.

Reset
REQ-016 While rst = 1, the block SHALL immediately and asynchronously force the state to IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, all wait counters to 0, the hold counter to 0, and the exclusion flag to clear.
REQ-017 Reset asserted during GRANT SHALL drop the grant in the same cycle without pulsing timeout; after rst falls, arbitration SHALL restart from IDLE on the next edge.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Static priority: req = 4'b0101 from IDLE -> after 1 edge gnt = 4'b0100, gnt_id = 2; drop req[2] -> gnt = 0 for 1 cycle, then gnt = 4'b0001, gnt_id = 0.
- No preemption: owner is bit 0 and req becomes 4'b1001 -> gnt stays 4'b0001 until req[0] falls.
- Starvation: bit 3 repeatedly re-requests with short grants while req[1] is held -> once wait_cnt[1] reaches 8, the next arbitration grants 4'b0010 despite req[3] = 1.
- Timeout: HOLD_MAX = 16 and req = 4'b1000 held -> gnt drops after 16 grant cycles, timeout pulses 1 cycle, the next winner is a lower requester if present, and bit 3 is re-granted after that.
- Async reset: rst pulsed mid-GRANT between edges -> gnt = 0 immediately, timeout stays 0, and the first grant after release is 1 edge later.
- Random: 10k cycles of random req -> popcount(gnt) <= 1 always, and no requester waits more than MAX_WAIT + 4*HOLD_MAX + 8 cycles.

Source files
------------

// File: rtl/priority_arbiter_4_req.sv
// Four-way fixed-priority arbiter with starvation override, per-grant hold limit
// and forced revocation (timeout). Grants are registered; one idle cycle between owners.
module priority_arbiter_4_req #(
    parameter int MAX_WAIT = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    // state  | meaning
    // IDLE   | no owner; arbitrate eligible requests at the next edge
    // GRANT  | one owner holds gnt until it drops req or the hold limit expires
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [4:0] HOLD_MAX_C = 5'(HOLD_MAX);

    state_t          r_state,     w_state_nxt;
    logic [3:0]      r_gnt,       w_gnt_nxt;
    logic [1:0]      r_gnt_id,    w_gnt_id_nxt;
    logic            r_gnt_valid, w_gnt_valid_nxt;
    logic            r_timeout,   w_timeout_nxt;
    logic [4:0]      r_hold,      w_hold_nxt;
    logic            r_excl,      w_excl_nxt;
    logic [1:0]      r_excl_id,   w_excl_id_nxt;
    logic [3:0][3:0] r_wait,      w_wait_nxt;

    logic [3:0] w_eligible;
    logic [3:0] w_starved;
    logic [3:0] w_pick;
    logic [1:0] w_win_id;
    logic       w_win_any;

    // A requester revoked by timeout sits out exactly one arbitration.
    always_comb begin
        w_eligible = req;
        if (r_excl) w_eligible[r_excl_id] = 1'b0;
        w_starved = '0;
        for (int i = 0; i < 4; i++) begin
            w_starved[i] = w_eligible[i] && (r_wait[i] >= MAX_WAIT_C);
        end
        w_pick    = (|w_starved) ? w_starved : w_eligible;
        w_win_any = |w_eligible;
        w_win_id  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_pick[i]) w_win_id = 2'(i);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        w_hold_nxt      = r_hold;
        w_excl_nxt      = r_excl;
        w_excl_id_nxt   = r_excl_id;
        case (r_state)
            ST_IDLE: begin
                w_excl_nxt = 1'b0;
                if (w_win_any) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_nxt       = 4'b0001 << w_win_id;
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = 5'd1;
                end
            end
            ST_GRANT: begin
                if (!req[r_gnt_id] || (r_hold == HOLD_MAX_C)) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_id_nxt    = 2'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_nxt      = 5'd0;
                    if (req[r_gnt_id]) begin
                        w_timeout_nxt = 1'b1;
                        w_excl_nxt    = 1'b1;
                        w_excl_id_nxt = r_gnt_id;
                    end
                end else begin
                    w_hold_nxt = r_hold + 5'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wait_nxt = r_wait;
        for (int i = 0; i < 4; i++) begin
            if (!req[i] || r_gnt[i] || w_gnt_nxt[i]) begin
                w_wait_nxt[i] = 4'd0;
            end else if (r_wait[i] != 4'd15) begin
                w_wait_nxt[i] = r_wait[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold      <= 5'd0;
            r_excl      <= 1'b0;
            r_excl_id   <= 2'd0;
            r_wait      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_hold      <= w_hold_nxt;
            r_excl      <= w_excl_nxt;
            r_excl_id   <= w_excl_id_nxt;
            r_wait      <= w_wait_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_priority_arbiter_4_req.sv
// Scoreboarded bench for priority_arbiter_4_req: directed scenarios then random
// traffic, checked against a cycle-level behavioural model of the arbitration rules.
module tb_priority_arbiter_4_req;

    localparam int MAX_WAIT = 8;
    localparam int HOLD_MAX = 16;
    localparam int BOUND    = MAX_WAIT + 4*HOLD_MAX + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    priority_arbiter_4_req #(.MAX_WAIT(MAX_WAIT), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    // model state: owner index or -1, hold count, excluded index or -1
    int m_owner = -1;
    int m_hold  = 0;
    int m_excl  = -1;
    int m_wait[4] = '{0, 0, 0, 0};
    bit m_tmo   = 1'b0;

    int run[4]     = '{0, 0, 0, 0};
    int max_run[4] = '{0, 0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {g, id, (m_owner >= 0), m_tmo};
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rr);
        int win;
        int nw[4];
        if (rr) begin
            m_owner = -1; m_hold = 0; m_excl = -1; m_tmo = 1'b0;
            for (int i = 0; i < 4; i++) m_wait[i] = 0;
            return;
        end
        win = -1;
        if (m_owner < 0) begin
            for (int i = 3; i >= 0; i--)
                if (win < 0 && r[i] && i != m_excl && m_wait[i] >= MAX_WAIT) win = i;
            for (int i = 3; i >= 0; i--)
                if (win < 0 && r[i] && i != m_excl) win = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (!r[i] || i == m_owner || i == win) nw[i] = 0;
            else nw[i] = (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
        end
        m_wait = nw;
        m_tmo  = 1'b0;
        if (m_owner < 0) begin
            m_excl = -1;
            if (win >= 0) begin
                m_owner = win;
                m_hold  = 1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
            m_hold  = 0;
        end else if (m_hold == HOLD_MAX) begin
            m_excl  = m_owner;
            m_owner = -1;
            m_hold  = 0;
            m_tmo   = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    // Called at a falling edge: drive req, predict the next rising edge, wait one cycle.
    task automatic cycle(input logic [3:0] r);
        req = r;
        model_step(r, rst);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    // monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", int'({gnt, gnt_id, gnt_valid, timeout}), int'(e));
            end
            n_checks++;
            if ($countones(gnt) <= 1) n_pass++;
            else $display("FAIL onehot: gnt=%b", gnt);
            for (int i = 0; i < 4; i++) begin
                if (!rst && req[i] && !gnt[i]) run[i]++;
                else run[i] = 0;
                if (run[i] > max_run[i]) max_run[i] = run[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] cur;
        #1;
        check("reset_outputs", int'({gnt, gnt_id, gnt_valid, timeout}), 0);
        @(negedge clk);
        cycle(4'b0000);
        cycle(4'b0000);
        rst = 1'b0;
        cycle(4'b0000);

        // static priority
        cycle(4'b0101);
        check("prio_first", int'({gnt, gnt_id}), int'({4'b0100, 2'd2}));
        cycle(4'b0001);
        check("prio_gap", int'(gnt), 0);
        cycle(4'b0001);
        check("prio_second", int'({gnt, gnt_id}), int'({4'b0001, 2'd0}));
        cycle(4'b0000);
        cycle(4'b0000);

        // no preemption
        cycle(4'b0001);
        repeat (3) cycle(4'b1001);
        check("no_preempt", int'(gnt), int'(4'b0001));
        cycle(4'b1000);
        check("no_preempt_drop", int'(gnt), 0);
        cycle(4'b1000);
        check("no_preempt_next", int'(gnt), int'(4'b1000));
        cycle(4'b0000);
        cycle(4'b0000);

        // starvation of bit 1 behind short grants to bit 3
        repeat (4) begin
            cycle(4'b1010);
            cycle(4'b0010);
        end
        cycle(4'b1010);
        check("starve_win", int'({gnt, gnt_id}), int'({4'b0010, 2'd1}));
        cycle(4'b0000);
        cycle(4'b0000);

        // hold limit and revocation
        repeat (HOLD_MAX + 1) cycle(4'b1000);
        check("timeout_drop", int'({gnt, timeout}), int'({4'b0000, 1'b1}));
        cycle(4'b1001);
        check("timeout_lower", int'({gnt, timeout}), int'({4'b0001, 1'b0}));
        cycle(4'b1000);
        cycle(4'b1000);
        check("timeout_regrant", int'(gnt), int'(4'b1000));
        cycle(4'b0000);
        cycle(4'b0000);

        // asynchronous reset mid-grant
        cycle(4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", int'({gnt, gnt_id, gnt_valid, timeout}), 0);
        model_step(req, 1'b1);
        exp_q.push_back(model_out());
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0100);
        check("post_reset_grant", int'(gnt), int'(4'b0100));
        cycle(4'b0000);

        // random traffic: each bit flips with low probability
        cur = 4'b0;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, (n < 5000) ? 3 : 15) == 0) cur[b] = ~cur[b];
            cycle(cur);
        end
        cycle(4'b0000);

        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (max_run[i] <= BOUND) n_pass++;
            else $display("FAIL max_wait[%0d]: got %0d limit %0d", i, max_run[i], BOUND);
        end
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
